gost_cbc_sched: RTL
===================

Name: gost_cbc_sched

Overview:
- Multi-channel CBC scheduler sharing one gost_enc block-cipher core between N_CH independent requesters.
- Holds a per-channel chaining IV and arbitrates requests round-robin.
- For the granted channel: XORs that channel's IV into the plaintext, starts the core, waits for completion, writes the ciphertext back as the new IV, returns it to the requester.
- Sits between the stream front-ends and the single gost_enc instance. The core is instantiated outside this block; only its ports are driven from here.

Parameters:
- N_CH, 4, number of requester channels (2..8).
- IV_INIT, 128'h00112233445566778899aabbccddeeff, reset value of every channel IV.
- TIMEOUT, 64, cycles allowed between core_start and core_done. Used only with the watchdog feature.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  N_CH  per-channel request. Held high, with req_data stable, until the matching req_ack.
- req_data  in  N_CH*128  plaintext blocks; channel i occupies bits [128*i+127:128*i].
- req_ack  out  N_CH  one-cycle one-hot pulse: the block for that channel has been latched.
- resp_valid  out  1  one-cycle pulse: resp_data/resp_ch valid.
- resp_ch  out  3  channel index of the response.
- resp_data  out  128  ciphertext block.
- iv_load  in  1  load iv_value into the IV of channel iv_ch.
- iv_ch  in  3  IV load target.
- iv_value  in  128  IV load value.
- busy  out  1  high whenever state is not IDLE.
- core_start  out  1  one-cycle start pulse to gost_enc.
- core_din  out  128  core input (IV ^ plaintext).
- core_dout  in  128  core output.
- core_done  in  1  core completion pulse.
- err_timeout  out  1  one-cycle pulse on watchdog abort. Tied 0 without the feature.

Behaviour:
- Reset (reset_n=0 at a clk edge), regardless of current state:
  - state to IDLE; all IVs to IV_INIT; rr pointer to N_CH-1 (channel 0 wins first).
  - req_ack, resp_valid, core_start, err_timeout, busy to 0.
  - resp_ch, resp_data, core_din to 0.
  - Any in-flight block is dropped with no response.
- States:
  - IDLE: if any req_valid is high, pick the granted channel g by searching from pointer+1 upward with wrap. Then:
    - core_din <= IV[g] ^ req_data[g], core_start <= 1, req_ack[g] <= 1.
    - pointer <= g, cur <= g, state <= WAIT.
    - Otherwise stay in IDLE.
  - WAIT: core_start and req_ack return to 0. When core_done is high:
    - IV[cur] <= core_dout, resp_data <= core_dout, resp_ch <= cur, resp_valid <= 1.
    - state <= IDLE.
- Latency:
  - req_valid sampled in IDLE at edge t gives core_start and req_ack high in cycle t+1.
  - core_done at edge d gives resp_valid in cycle d+1.
  - The next grant is evaluated no earlier than the edge after resp_valid. At most one block is in flight.
- core_done while in IDLE is ignored. Requesters must drop req_valid on the cycle after req_ack; the earliest re-sample is after completion, so no double grant occurs.
- req_valid falling before ack is a protocol violation and is not checked.
- iv_load is accepted in any state and takes effect the next cycle.
  - If iv_load targets cur in the same cycle as the WAIT write-back, the write-back wins.
  - iv_ch >= N_CH is ignored.
- A non-granted channel keeps req_valid pending; the round-robin order guarantees service within N_CH transactions.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: GOST_SCHED_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without core_done: state <= IDLE, err_timeout pulses one cycle, resp_ch <= cur, no resp_valid, IV[cur] unchanged.
  - A core_done arriving on the same edge as the timeout wins (normal response, no error).
- Not defined: no counter; WAIT waits indefinitely; err_timeout constant 0.

Test Plan:
- Single request, channel 0, data 0, core model = identity with 10-cycle latency:
  - req_ack[0] pulses 1 cycle after req_valid.
  - core_din = IV_INIT.
  - resp_data = IV_INIT, resp_ch = 0.
  - IV[0] = IV_INIT; a second zero block yields core_din = IV_INIT.
- Chaining on channel 1, data 128'h1 then 128'h2 (identity core):
  - second core_din = (IV_INIT^1)^2.
- All 4 channels valid simultaneously from reset:
  - grants in order 0,1,2,3.
  - then, with channels 3 and 0 re-requesting, 0 is granted before 3.
- iv_load channel 2 to 128'hFF while channel 0 is in flight, then a channel 2 request with data 128'h0F:
  - core_din = 128'hF0.
- reset_n low for 1 cycle during WAIT, then core_done pulses:
  - no resp_valid; busy = 0; IVs = IV_INIT.
- With GOST_SCHED_WATCHDOG_EN defined, TIMEOUT=64, core never returns done:
  - err_timeout pulses 64 cycles after core_start.
  - busy drops; the next request is served normally.

Source files
------------

// File: rtl/gost_cbc_sched.sv
// gost_cbc_sched: round-robin CBC scheduler sharing one gost_enc core between
// N_CH requesters, with per-channel chaining IVs.
// Optional watchdog abort when GOST_SCHED_WATCHDOG_EN is defined.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   req_valid/req_data/req_ack    per-channel plaintext requests and latch ack
//   resp_valid/resp_ch/resp_data  ciphertext response pulse
//   iv_load/iv_ch/iv_value        direct IV overwrite
//   busy                          high while a block is in flight
//   core_start/core_din           drive to gost_enc
//   core_dout/core_done           return from gost_enc
//   err_timeout                   watchdog abort pulse (0 without watchdog)
module gost_cbc_sched #(
    parameter int unsigned  N_CH    = 4,
    parameter logic [127:0] IV_INIT = 128'h00112233445566778899aabbccddeeff,
    parameter int unsigned  TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_CH-1:0]     req_valid,
    input  logic [N_CH*128-1:0] req_data,
    output logic [N_CH-1:0]     req_ack,
    output logic                resp_valid,
    output logic [2:0]          resp_ch,
    output logic [127:0]        resp_data,
    input  logic                iv_load,
    input  logic [2:0]          iv_ch,
    input  logic [127:0]        iv_value,
    output logic                busy,
    output logic                core_start,
    output logic [127:0]        core_din,
    input  logic [127:0]        core_dout,
    input  logic                core_done,
    output logic                err_timeout
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              r_state;
    logic [127:0]        r_iv [0:7];
    logic [2:0]          r_ptr;
    logic [2:0]          r_cur;
    logic [N_CH-1:0]     r_ack;
    logic                r_rv;
    logic [2:0]          r_ch;
    logic [127:0]        r_rd;
    logic                r_busy;
    logic                r_start;
    logic [127:0]        r_din;

    // Requests padded to the 8-channel maximum so 3-bit indices are exact.
    logic [7:0]          w_rv;
    logic [1023:0]       w_rd;
    logic                w_any;
    logic [2:0]          w_gnt;
    logic [7:0]          w_oh;

    assign w_rv = 8'(req_valid);
    assign w_rd = 1024'(req_data);
    assign w_oh = 8'(1) << w_gnt;

    // Scan from pointer+1 with wrap; iterating downward lets the nearest
    // requester overwrite any farther one.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        for (int unsigned k = N_CH; k >= 1; k--) begin
            if (w_rv[3'((32'(r_ptr) + k) % N_CH)]) begin
                w_any = 1'b1;
                w_gnt = 3'((32'(r_ptr) + k) % N_CH);
            end
        end
    end

`ifdef GOST_SCHED_WATCHDOG_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_to;
    assign err_timeout = r_to;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            for (int i = 0; i < 8; i++) r_iv[i] <= IV_INIT;
            r_ptr   <= 3'(N_CH - 1);
            r_cur   <= '0;
            r_ack   <= '0;
            r_rv    <= 1'b0;
            r_ch    <= '0;
            r_rd    <= '0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_din   <= '0;
`ifdef GOST_SCHED_WATCHDOG_EN
            r_cnt   <= '0;
            r_to    <= 1'b0;
`endif
        end else begin
            r_ack   <= '0;
            r_start <= 1'b0;
            r_rv    <= 1'b0;
`ifdef GOST_SCHED_WATCHDOG_EN
            r_to    <= 1'b0;
`endif
            // Placed before the write-back so the write-back wins a collision.
            if (iv_load && (32'(iv_ch) < N_CH))
                r_iv[iv_ch] <= iv_value;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_din   <= r_iv[w_gnt] ^ w_rd[128*w_gnt +: 128];
                        r_start <= 1'b1;
                        r_ack   <= w_oh[N_CH-1:0];
                        r_ptr   <= w_gnt;
                        r_cur   <= w_gnt;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
`ifdef GOST_SCHED_WATCHDOG_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_iv[r_cur] <= core_dout;
                        r_rd        <= core_dout;
                        r_ch        <= r_cur;
                        r_rv        <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
`ifdef GOST_SCHED_WATCHDOG_EN
                    else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_to    <= 1'b1;
                        r_ch    <= r_cur;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ack    = r_ack;
    assign resp_valid = r_rv;
    assign resp_ch    = r_ch;
    assign resp_data  = r_rd;
    assign busy       = r_busy;
    assign core_start = r_start;
    assign core_din   = r_din;

endmodule
